// File: rtl/y86_execute_stage.sv
// Y86-64 sequential execute stage: valE ALU, condition evaluation and the CC register.
// Optional build macro EXE_MULQ_EN enables OPq ifun 4 (mulq).
module y86_execute_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [63:0] valA,
    input  logic [63:0] valB,
    input  logic [63:0] valC,
    output logic        cnd,
    output logic [2:0]  CC,
    output logic [63:0] valE
);

    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] F_ADD = 4'h0;
    localparam logic [3:0] F_SUB = 4'h1;
    localparam logic [3:0] F_AND = 4'h2;
    localparam logic [3:0] F_XOR = 4'h3;
    localparam logic [3:0] F_MUL = 4'h4;

    localparam logic [63:0] STACK_WORD = 64'd8;

    logic [63:0] op_sum;
    logic [63:0] op_diff;
    logic [63:0] opq_t;
    logic        opq_of;
    logic        cc_we;
    logic        zf;
    logic        sf;
    logic        of;

    assign op_sum  = valB + valA;
    assign op_diff = valB - valA;

`ifdef EXE_MULQ_EN
    logic [63:0] op_prod;
    // Low 64 bits of a product are identical for signed and unsigned operands.
    assign op_prod = valB * valA;
`endif

    // NOTE: every signal written below gets a default first, so no path leaves a latch behind.
    always_comb begin
        opq_t  = '0;
        opq_of = 1'b0;
        cc_we  = 1'b0;
        if (icode == I_OPQ) begin
            case (ifun)
                F_ADD: begin
                    opq_t  = op_sum;
                    opq_of = (valA[63] == valB[63]) && (op_sum[63] != valA[63]);
                    cc_we  = 1'b1;
                end
                F_SUB: begin
                    opq_t  = op_diff;
                    opq_of = (valA[63] != valB[63]) && (op_diff[63] != valB[63]);
                    cc_we  = 1'b1;
                end
                F_AND: begin
                    opq_t = valB & valA;
                    cc_we = 1'b1;
                end
                F_XOR: begin
                    opq_t = valB ^ valA;
                    cc_we = 1'b1;
                end
`ifdef EXE_MULQ_EN
                F_MUL: begin
                    opq_t = op_prod;
                    cc_we = 1'b1;
                end
`endif
                default: begin
                    opq_t = '0;
                    cc_we = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        valE = '0;
        case (icode)
            I_RRMOVQ:          valE = valA;
            I_IRMOVQ:          valE = valC;
            I_RMMOVQ, I_MRMOVQ: valE = valB + valC;
            I_OPQ:             valE = opq_t;
            I_CALL, I_PUSHQ:   valE = valB - STACK_WORD;
            I_RET, I_POPQ:     valE = valB + STACK_WORD;
            default:           valE = '0;
        endcase
    end

    assign zf = CC[2];
    assign sf = CC[1];
    assign of = CC[0];

    // Conditions read the committed CC, never the flags being produced this cycle.
    always_comb begin
        cnd = 1'b0;
        if (icode == I_RRMOVQ || icode == I_JXX) begin
            case (ifun)
                4'h0:    cnd = 1'b1;
                4'h1:    cnd = (sf ^ of) | zf;
                4'h2:    cnd = sf ^ of;
                4'h3:    cnd = zf;
                4'h4:    cnd = ~zf;
                4'h5:    cnd = ~(sf ^ of);
                4'h6:    cnd = ~(sf ^ of) & ~zf;
                default: cnd = 1'b0;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            CC <= 3'b100;
        end else if (cc_we) begin
            CC <= {(opq_t == 64'd0), opq_t[63], opq_of};
        end
    end

endmodule

// File: tb/tb_y86_execute_stage.sv
// Directed self-checking bench for y86_execute_stage; honours EXE_MULQ_EN for the mulq case.
module tb_y86_execute_stage;

    logic        clk;
    logic        reset;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valC;
    logic        cnd;
    logic [2:0]  CC;
    logic [63:0] valE;

    int n_checks = 0;
    int n_fail   = 0;

    y86_execute_stage dut (
        .clk   (clk),
        .reset (reset),
        .icode (icode),
        .ifun  (ifun),
        .valA  (valA),
        .valB  (valB),
        .valC  (valC),
        .cnd   (cnd),
        .CC    (CC),
        .valE  (valE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        icode = ic; ifun = fn; valA = a; valB = b; valC = c;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(4'h1, 4'h0, 64'd0, 64'd0, 64'd0);
        tick();
        n_checks++; if (CC !== 3'b100) begin n_fail++; $display("FAIL reset_cc got %b exp %b", CC, 3'b100); end
        reset = 1'b0;
        // sub 0x7FFF.. - (-1): negative result with overflow -> CC 011
        drive(4'h6, 4'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
        tick();
        n_checks++; if (CC !== 3'b011) begin n_fail++; $display("FAIL pre_reset_cc got %b exp %b", CC, 3'b011); end
        #3;
        reset = 1'b1;
        #1;
        n_checks++; if (CC !== 3'b100) begin n_fail++; $display("FAIL async_reset_cc got %b exp %b", CC, 3'b100); end
        tick();
        n_checks++; if (CC !== 3'b100) begin n_fail++; $display("FAIL reset_hold_cc got %b exp %b", CC, 3'b100); end
        reset = 1'b0;
    endtask

    task automatic test_opq_zero();
        drive(4'h6, 4'h2, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0);
        tick();
        n_checks++; if (CC !== 3'b010) begin n_fail++; $display("FAIL and_sign_cc got %b exp %b", CC, 3'b010); end
        drive(4'h6, 4'h0, 64'd0, 64'd0, 64'd0);
        n_checks++; if (valE !== 64'd0) begin n_fail++; $display("FAIL add_zero_vale got %h exp %h", valE, 64'd0); end
        n_checks++; if (CC !== 3'b010) begin n_fail++; $display("FAIL cc_before_edge got %b exp %b", CC, 3'b010); end
        tick();
        n_checks++; if (CC !== 3'b100) begin n_fail++; $display("FAIL add_zero_cc got %b exp %b", CC, 3'b100); end
    endtask

    task automatic test_jxx();
        drive(4'h7, 4'h2, 64'd5, 64'd14, 64'd2);
        n_checks++; if (valE !== 64'd0) begin n_fail++; $display("FAIL jl_vale got %h exp %h", valE, 64'd0); end
        n_checks++; if (cnd !== 1'b0) begin n_fail++; $display("FAIL jl_cnd got %b exp %b", cnd, 1'b0); end
        drive(4'h7, 4'h3, 64'd5, 64'd14, 64'd2);
        n_checks++; if (cnd !== 1'b1) begin n_fail++; $display("FAIL je_cnd got %b exp %b", cnd, 1'b1); end
        drive(4'h7, 4'h4, 64'd5, 64'd14, 64'd2);
        n_checks++; if (cnd !== 1'b0) begin n_fail++; $display("FAIL jne_cnd got %b exp %b", cnd, 1'b0); end
        tick();
        tick();
        n_checks++; if (CC !== 3'b100) begin n_fail++; $display("FAIL jxx_cc_hold got %b exp %b", CC, 3'b100); end
    endtask

    task automatic test_sub_overflow();
        drive(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0);
        n_checks++; if (valE !== 64'h7FFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL sub_of_vale got %h exp %h", valE, 64'h7FFF_FFFF_FFFF_FFFF); end
        n_checks++; if (cnd !== 1'b0) begin n_fail++; $display("FAIL opq_cnd got %b exp %b", cnd, 1'b0); end
        tick();
        n_checks++; if (CC !== 3'b001) begin n_fail++; $display("FAIL sub_of_cc got %b exp %b", CC, 3'b001); end
        drive(4'h2, 4'h2, 64'h1234_5678_9ABC_DEF0, 64'd7, 64'd0);
        n_checks++; if (cnd !== 1'b1) begin n_fail++; $display("FAIL cmovl_cnd got %b exp %b", cnd, 1'b1); end
        n_checks++; if (valE !== 64'h1234_5678_9ABC_DEF0) begin n_fail++; $display("FAIL cmovl_vale got %h exp %h", valE, 64'h1234_5678_9ABC_DEF0); end
        drive(4'h2, 4'h1, 64'd0, 64'd0, 64'd0);
        n_checks++; if (cnd !== 1'b1) begin n_fail++; $display("FAIL cmovle_cnd got %b exp %b", cnd, 1'b1); end
        drive(4'h2, 4'h5, 64'd0, 64'd0, 64'd0);
        n_checks++; if (cnd !== 1'b0) begin n_fail++; $display("FAIL cmovge_cnd got %b exp %b", cnd, 1'b0); end
        drive(4'h2, 4'h6, 64'd0, 64'd0, 64'd0);
        n_checks++; if (cnd !== 1'b0) begin n_fail++; $display("FAIL cmovg_cnd got %b exp %b", cnd, 1'b0); end
        drive(4'h2, 4'h0, 64'd0, 64'd0, 64'd0);
        n_checks++; if (cnd !== 1'b1) begin n_fail++; $display("FAIL rrmovq_cnd got %b exp %b", cnd, 1'b1); end
        drive(4'h7, 4'h7, 64'd0, 64'd0, 64'd0);
        n_checks++; if (cnd !== 1'b0) begin n_fail++; $display("FAIL jxx_bad_ifun_cnd got %b exp %b", cnd, 1'b0); end
    endtask

    task automatic test_addr_arith();
        drive(4'h8, 4'h0, 64'd0, 64'h100, 64'd0);
        n_checks++; if (valE !== 64'hF8) begin n_fail++; $display("FAIL call_vale got %h exp %h", valE, 64'hF8); end
        drive(4'hB, 4'h0, 64'd0, 64'h100, 64'd0);
        n_checks++; if (valE !== 64'h108) begin n_fail++; $display("FAIL popq_vale got %h exp %h", valE, 64'h108); end
        drive(4'h4, 4'h0, 64'd0, 64'h10, 64'hFFFF_FFFF_FFFF_FFF8);
        n_checks++; if (valE !== 64'h8) begin n_fail++; $display("FAIL rmmovq_vale got %h exp %h", valE, 64'h8); end
        tick();
        n_checks++; if (CC !== 3'b001) begin n_fail++; $display("FAIL addr_cc_hold got %b exp %b", CC, 3'b001); end
        drive(4'hA, 4'h0, 64'd0, 64'd0, 64'd0);
        n_checks++; if (valE !== 64'hFFFF_FFFF_FFFF_FFF8) begin n_fail++; $display("FAIL pushq_wrap_vale got %h exp %h", valE, 64'hFFFF_FFFF_FFFF_FFF8); end
        drive(4'h9, 4'h0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0);
        n_checks++; if (valE !== 64'h4) begin n_fail++; $display("FAIL ret_wrap_vale got %h exp %h", valE, 64'h4); end
        drive(4'h5, 4'h0, 64'd0, 64'h20, 64'h30);
        n_checks++; if (valE !== 64'h50) begin n_fail++; $display("FAIL mrmovq_vale got %h exp %h", valE, 64'h50); end
        drive(4'h3, 4'h0, 64'd9, 64'd9, 64'hDEAD_BEEF);
        n_checks++; if (valE !== 64'hDEAD_BEEF) begin n_fail++; $display("FAIL irmovq_vale got %h exp %h", valE, 64'hDEAD_BEEF); end
        drive(4'h0, 4'h0, 64'd9, 64'd9, 64'd9);
        n_checks++; if (valE !== 64'd0) begin n_fail++; $display("FAIL halt_vale got %h exp %h", valE, 64'd0); end
        drive(4'hC, 4'h0, 64'd9, 64'd9, 64'd9);
        n_checks++; if (valE !== 64'd0) begin n_fail++; $display("FAIL invalid_icode_vale got %h exp %h", valE, 64'd0); end
    endtask

    task automatic test_logic_ops();
        drive(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
        n_checks++; if (valE !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_fail++; $display("FAIL add_of_vale got %h exp %h", valE, 64'hFFFF_FFFF_FFFF_FFFE); end
        tick();
        n_checks++; if (CC !== 3'b011) begin n_fail++; $display("FAIL add_of_cc got %b exp %b", CC, 3'b011); end
        drive(4'h7, 4'h5, 64'd0, 64'd0, 64'd0);
        n_checks++; if (cnd !== 1'b1) begin n_fail++; $display("FAIL jge_cnd got %b exp %b", cnd, 1'b1); end
        drive(4'h6, 4'h3, 64'h0F0F, 64'h0F0F, 64'd0);
        n_checks++; if (valE !== 64'd0) begin n_fail++; $display("FAIL xor_vale got %h exp %h", valE, 64'd0); end
        tick();
        n_checks++; if (CC !== 3'b100) begin n_fail++; $display("FAIL xor_cc got %b exp %b", CC, 3'b100); end
        drive(4'h6, 4'h2, 64'h0FF0, 64'h00FF, 64'd0);
        n_checks++; if (valE !== 64'h00F0) begin n_fail++; $display("FAIL and_vale got %h exp %h", valE, 64'h00F0); end
        tick();
        n_checks++; if (CC !== 3'b000) begin n_fail++; $display("FAIL and_cc got %b exp %b", CC, 3'b000); end
    endtask

    task automatic test_mulq_and_invalid();
        logic [63:0] exp_vale;
        logic [2:0]  exp_cc;
`ifdef EXE_MULQ_EN
        exp_vale = 64'hFFFF_FFFF_FFFF_FFFA;
        exp_cc   = 3'b010;
`else
        exp_vale = 64'd0;
        exp_cc   = 3'b000;
`endif
        drive(4'h6, 4'h4, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0);
        n_checks++; if (valE !== exp_vale) begin n_fail++; $display("FAIL mulq_vale got %h exp %h", valE, exp_vale); end
        tick();
        n_checks++; if (CC !== exp_cc) begin n_fail++; $display("FAIL mulq_cc got %b exp %b", CC, exp_cc); end
        drive(4'h6, 4'h5, 64'd3, 64'd3, 64'd0);
        n_checks++; if (valE !== 64'd0) begin n_fail++; $display("FAIL opq_bad_ifun_vale got %h exp %h", valE, 64'd0); end
        tick();
        n_checks++; if (CC !== exp_cc) begin n_fail++; $display("FAIL opq_bad_ifun_cc got %b exp %b", CC, exp_cc); end
        drive(4'h1, 4'hx, 64'hx, 64'hx, 64'hx);
        tick();
        n_checks++; if (CC !== exp_cc) begin n_fail++; $display("FAIL unknown_inputs_cc got %b exp %b", CC, exp_cc); end
    endtask

    initial begin
        test_reset();
        test_opq_zero();
        test_jxx();
        test_sub_overflow();
        test_addr_arith();
        test_logic_ops();
        test_mulq_and_invalid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
